control_mc: RTL and testbench
=============================

# control_mc

Multi-cycle control unit for the 3-bit-opcode core (ADD, ADDI, NAND, LUI, LW, SW, BEQ, JALR). It sequences each instruction through fetch, decode, execute and memory states over a single shared memory port with a req/ack handshake. It drives the same datapath select fields as the single-cycle decoder, plus register-file, PC and IR write strobes. It adds halt, memory timeout fault and a retired-instruction counter.

## Interface
- `DECODE_STAGE`, default 1: 1 = separate DECODE state; 0 = FETCH goes directly to EXEC.
- `TIMEOUT`, default 16: max cycles `mem_req` may wait for `mem_ack` before fault; 0 disables the timeout.
- `RETIRE_W`, default 16: width of `instret`.
- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 3: opcode field from the instruction register.
- `eq` in 1: ALU equality result.
- `halt` in 1: request to pause at the next instruction boundary.
- `mem_ack` in 1: memory completes the access on the clock edge where `mem_req & mem_ack`.
- `mem_req` out 1: memory access request.
- `mem_sel` out 1: 0 = instruction fetch, 1 = data access.
- `mem_we` out 1: data write (SW only).
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: update the PC from `mux_pc`.
- `we_rf` out 1: register-file write.
- `func_alu` out 2: 00 ADD, 01 NAND, 10 PASS1, 11 EQ.
- `mux_alu1` out 1: ALU input 1 select.
- `mux_alu2` out 1: ALU input 2 select.
- `mux_rf` out 1: register-file read-port select.
- `mux_pc` out 2: 01 NEXT, 10 BRANCH, 11 JUMP.
- `mux_tgt` out 2: 01 ALU, 10 DMEM, 11 PC.
- `halted` out 1: FSM is in HALT.
- `fault` out 1: sticky memory timeout.
- `instret` out RETIRE_W: count of retired instructions.

## Operation
- States: HALT, FETCH, DECODE, EXEC, MEM, FAULT.
- Reset enters HALT.
- HALT:
  - `halted`=1; no requests.
  - If `halt`=0, next state is FETCH.
- FETCH:
  - `mem_req`=1, `mem_sel`=0, `mem_we`=0.
  - On ack: `ir_we`=1; next state is DECODE (or EXEC if `DECODE_STAGE`=0).
- DECODE: one cycle, no strobes; next state is EXEC.
- EXEC:
  - ADD, ADDI, NAND, LUI: `we_rf`=1, `pc_we`=1, `mux_pc`=01.
  - BEQ: `pc_we`=1, `mux_pc` = `eq` ? 10 : 01.
  - JALR: `we_rf`=1, `mux_tgt`=11, `pc_we`=1, `mux_pc`=11.
  - These opcodes retire in EXEC. LW and SW go to MEM with no strobes in EXEC.
- MEM:
  - `mem_req`=1, `mem_sel`=1, `mem_we` = (opcode==SW).
  - On ack: LW pulses `we_rf`=1 with `mux_tgt`=10. Both LW and SW pulse `pc_we`=1 with `mux_pc`=01, and the instruction retires.
- After retire: next state is HALT if `halt`=1, else FETCH.
- Select fields (`func_alu`, `mux_*`) decode combinationally from `opcode` in every state.
  - func_alu: ADD, ADDI, LW, SW → 00; NAND → 01; LUI, JALR → 10; BEQ → 11.
  - mux_alu1: 1 only for LUI.
  - mux_alu2: 1 for ADDI, LW, SW; otherwise 0.
  - mux_rf: 1 for SW, BEQ; otherwise 0.
  - mux_tgt: 10 for LW; 11 for JALR; otherwise 01.
  - mux_pc: 01 except in the BEQ/JALR EXEC cases above.
- Strobes (`ir_we`, `we_rf`, `pc_we`, `mem_we`) and `mem_req` are asserted only in the cases listed above.
- `instret` increments by 1 on each retire cycle and wraps modulo 2^RETIRE_W.
- Timeout:
  - The wait counter resets on entry to FETCH or MEM and counts cycles with `mem_req`=1 and `mem_ack`=0.
  - When it reaches `TIMEOUT` (if nonzero), next state is FAULT.
- FAULT: `fault`=1; all strobes and `mem_req` are 0. Exit is by `rst` only.

## Timing
- Reset values:
  - state HALT; `halted`=1; `fault`=0; `instret`=0.
  - All strobes and `mem_req` 0.
  - `mux_pc`=01; other selects follow `opcode`.
- Handshake:
  - Once `mem_req` rises, it stays high with stable `mem_sel`/`mem_we` until the ack edge or FAULT.
  - `halt` never withdraws a pending request.
  - Zero-wait memory (ack in the same cycle as req) is legal.
- Latency with zero-wait memory, from FETCH entry:
  - ALU/BEQ/JALR: 3 cycles (2 if `DECODE_STAGE`=0).
  - LW/SW: 4 cycles.
  - Each wait cycle adds 1.
- `halt` is sampled only at the retire edge and in HALT. Asserting it mid-instruction completes that instruction first.
- `rst` mid-instruction: next cycle is HALT with reset values. A pending request is dropped without ack.
- FAULT is entered on the edge where the wait count equals `TIMEOUT`, so `mem_req` was high for exactly `TIMEOUT` cycles.

## Test plan
- Reset, `halt`=0, `mem_ack`=1, `opcode`=ADD:
  - HALT→FETCH→DECODE→EXEC.
  - `ir_we` in FETCH; `we_rf`=1, `pc_we`=1, `mux_pc`=01 in EXEC.
  - `instret`=1 after EXEC.
- BEQ:
  - `eq`=1 → EXEC `pc_we`=1, `mux_pc`=10, `we_rf`=0.
  - `eq`=0 → `mux_pc`=01.
  - JALR → `mux_pc`=11, `mux_tgt`=11, `we_rf`=1.
- LW with ack delayed 3 cycles in MEM:
  - `mem_req`=1, `mem_sel`=1, `mem_we`=0 held for 4 cycles.
  - `we_rf`=1, `mux_tgt`=10 on the ack cycle; total 7 cycles.
- SW: MEM shows `mem_we`=1, `mux_alu2`=1, `mux_rf`=1; `we_rf` never 1.
- `TIMEOUT`=8, `mem_ack`=0:
  - `fault`=1 after 8 request cycles, `mem_req`=0, stays so until `rst`.
  - `rst` clears it; `instret`=0.
- `halt` raised during LW MEM wait:
  - LW completes, then `halted`=1, no `mem_req`.
  - Drop `halt` → FETCH next cycle.
  - With `RETIRE_W`=2, four retires → `instret`=0.

Source files
------------

// File: rtl/control_mc.sv
// Multi-cycle control unit for the 3-bit-opcode core: sequences fetch/decode/execute/memory
// over one shared req/ack memory port, with halt, memory timeout fault and a retire counter.
module control_mc #(
    parameter int DECODE_STAGE = 1,
    parameter int TIMEOUT      = 16,
    parameter int RETIRE_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          opcode,
    input  logic                eq,
    input  logic                halt,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_sel,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic                we_rf,
    output logic [1:0]          func_alu,
    output logic                mux_alu1,
    output logic                mux_alu2,
    output logic                mux_rf,
    output logic [1:0]          mux_pc,
    output logic [1:0]          mux_tgt,
    output logic                halted,
    output logic                fault,
    output logic [RETIRE_W-1:0] instret
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    // The wait counter only has to reach TIMEOUT-1; the fault fires on that no-ack edge.
    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_FAULT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          wait_expired;
    logic          retire;
    logic          is_mem_op;

    assign is_mem_op    = (opcode == OP_LW) || (opcode == OP_SW);
    assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign halted       = (state == S_HALT);
    assign fault        = (state == S_FAULT);

    always_comb begin
        func_alu = 2'b00;
        mux_alu1 = 1'b0;
        mux_alu2 = 1'b0;
        mux_rf   = 1'b0;
        mux_tgt  = 2'b01;
        case (opcode)
            OP_ADD:  func_alu = 2'b00;
            OP_ADDI: mux_alu2 = 1'b1;
            OP_NAND: func_alu = 2'b01;
            OP_LUI: begin
                func_alu = 2'b10;
                mux_alu1 = 1'b1;
            end
            OP_LW: begin
                mux_alu2 = 1'b1;
                mux_tgt  = 2'b10;
            end
            OP_SW: begin
                mux_alu2 = 1'b1;
                mux_rf   = 1'b1;
            end
            OP_BEQ: begin
                func_alu = 2'b11;
                mux_rf   = 1'b1;
            end
            OP_JALR: begin
                func_alu = 2'b10;
                mux_tgt  = 2'b11;
            end
            default: func_alu = 2'b00;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_sel    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        we_rf      = 1'b0;
        mux_pc     = 2'b01;
        retire     = 1'b0;
        case (state)
            S_HALT: begin
                if (!halt) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    state_next = (DECODE_STAGE != 0) ? S_DECODE : S_EXEC;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_mem_op) begin
                    state_next = S_MEM;
                end else begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    case (opcode)
                        OP_BEQ:  mux_pc = eq ? 2'b10 : 2'b01;
                        OP_JALR: begin
                            we_rf  = 1'b1;
                            mux_pc = 2'b11;
                        end
                        default: we_rf = 1'b1;
                    endcase
                    state_next = halt ? S_HALT : S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ack) begin
                    we_rf      = (opcode == OP_LW);
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = halt ? S_HALT : S_FETCH;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_HALT;
        else     state <= state_next;
    end

    // Any state change restarts the wait count, so each FETCH/MEM entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst)                        wait_cnt <= '0;
        else if (state_next != state)   wait_cnt <= '0;
        else if (mem_req && !mem_ack)   wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + 1'b1;
    end

endmodule

// File: tb/tb_control_mc.sv
// Directed self-checking bench for control_mc: one main instance (TIMEOUT=8, RETIRE_W=2)
// and one instance without the decode stage.
module tb_control_mc;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    logic        clk = 1'b0;
    logic        rst, rst2, halt, halt2, mem_ack, eq;
    logic [2:0]  opcode;

    logic        mem_req, mem_sel, mem_we, ir_we, pc_we, we_rf;
    logic [1:0]  func_alu, mux_pc, mux_tgt;
    logic        mux_alu1, mux_alu2, mux_rf, halted, fault;
    logic [1:0]  instret;

    logic        nd_mem_req, nd_mem_sel, nd_mem_we, nd_ir_we, nd_pc_we, nd_we_rf;
    logic [1:0]  nd_func_alu, nd_mux_pc, nd_mux_tgt;
    logic        nd_mux_alu1, nd_mux_alu2, nd_mux_rf, nd_halted, nd_fault;
    logic [15:0] nd_instret;

    logic [5:0]  strb;
    logic [5:0]  nd_strb;
    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  exp_ret;

    // Strobe bundle order: {mem_req, mem_sel, mem_we, ir_we, pc_we, we_rf}
    assign strb    = {mem_req, mem_sel, mem_we, ir_we, pc_we, we_rf};
    assign nd_strb = {nd_mem_req, nd_mem_sel, nd_mem_we, nd_ir_we, nd_pc_we, nd_we_rf};

    always #5 clk = ~clk;

    control_mc #(.DECODE_STAGE(1), .TIMEOUT(8), .RETIRE_W(2)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .halt(halt), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .we_rf(we_rf), .func_alu(func_alu), .mux_alu1(mux_alu1),
        .mux_alu2(mux_alu2), .mux_rf(mux_rf), .mux_pc(mux_pc), .mux_tgt(mux_tgt),
        .halted(halted), .fault(fault), .instret(instret)
    );

    control_mc #(.DECODE_STAGE(0), .TIMEOUT(16), .RETIRE_W(16)) u_nd (
        .clk(clk), .rst(rst2), .opcode(opcode), .eq(eq), .halt(halt2), .mem_ack(mem_ack),
        .mem_req(nd_mem_req), .mem_sel(nd_mem_sel), .mem_we(nd_mem_we), .ir_we(nd_ir_we),
        .pc_we(nd_pc_we), .we_rf(nd_we_rf), .func_alu(nd_func_alu), .mux_alu1(nd_mux_alu1),
        .mux_alu2(nd_mux_alu2), .mux_rf(nd_mux_rf), .mux_pc(nd_mux_pc), .mux_tgt(nd_mux_tgt),
        .halted(nd_halted), .fault(nd_fault), .instret(nd_instret)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // From HALT with halt=0 and zero-wait fetch, advances to the EXEC cycle.
    task automatic to_exec();
        halt    = 1'b0;
        mem_ack = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; halt = 1'b1; halt2 = 1'b1;
        mem_ack = 1'b0; eq = 1'b0; opcode = OP_ADD;
        next_cycle();
        next_cycle();
        rst = 1'b0; rst2 = 1'b0;
        exp_ret = 2'd0;
        #1;
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=1", halted); end
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (instret !== 2'd0) begin failures++; $display("[TB] FAIL reset_instret got=%0d exp=0", instret); end
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL reset_strb got=%b exp=000000", strb); end
        checks++; if (mux_pc !== 2'b01) begin failures++; $display("[TB] FAIL reset_mux_pc got=%b exp=01", mux_pc); end
        checks++; if (mux_tgt !== 2'b01) begin failures++; $display("[TB] FAIL reset_mux_tgt got=%b exp=01", mux_tgt); end
        checks++; if (nd_halted !== 1'b1) begin failures++; $display("[TB] FAIL reset_nd_halted got=%b exp=1", nd_halted); end
    endtask

    task automatic test_add();
        halt = 1'b0; mem_ack = 1'b1; opcode = OP_ADD;
        #1;
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL add_halt_strb got=%b exp=000000", strb); end
        next_cycle();
        checks++; if (strb !== 6'b100100) begin failures++; $display("[TB] FAIL add_fetch_strb got=%b exp=100100", strb); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL add_fetch_halted got=%b exp=0", halted); end
        next_cycle();
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL add_decode_strb got=%b exp=000000", strb); end
        next_cycle();
        halt = 1'b1;
        #1;
        checks++; if (strb !== 6'b000011) begin failures++; $display("[TB] FAIL add_exec_strb got=%b exp=000011", strb); end
        checks++; if (mux_pc !== 2'b01) begin failures++; $display("[TB] FAIL add_exec_mux_pc got=%b exp=01", mux_pc); end
        checks++; if (func_alu !== 2'b00) begin failures++; $display("[TB] FAIL add_func_alu got=%b exp=00", func_alu); end
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL add_instret_pre got=%0d exp=%0d", instret, exp_ret); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL add_halted got=%b exp=1", halted); end
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL add_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_beq_jalr();
        opcode = OP_BEQ; eq = 1'b1;
        to_exec();
        checks++; if (strb !== 6'b000010) begin failures++; $display("[TB] FAIL beq_taken_strb got=%b exp=000010", strb); end
        checks++; if (mux_pc !== 2'b10) begin failures++; $display("[TB] FAIL beq_taken_mux_pc got=%b exp=10", mux_pc); end
        checks++; if (func_alu !== 2'b11) begin failures++; $display("[TB] FAIL beq_func_alu got=%b exp=11", func_alu); end
        checks++; if (mux_rf !== 1'b1) begin failures++; $display("[TB] FAIL beq_mux_rf got=%b exp=1", mux_rf); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        eq = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (strb !== 6'b000010) begin failures++; $display("[TB] FAIL beq_not_strb got=%b exp=000010", strb); end
        checks++; if (mux_pc !== 2'b01) begin failures++; $display("[TB] FAIL beq_not_mux_pc got=%b exp=01", mux_pc); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        opcode = OP_JALR;
        next_cycle();
        checks++; if (mux_pc !== 2'b01) begin failures++; $display("[TB] FAIL jalr_decode_mux_pc got=%b exp=01", mux_pc); end
        next_cycle();
        halt = 1'b1;
        #1;
        checks++; if (strb !== 6'b000011) begin failures++; $display("[TB] FAIL jalr_strb got=%b exp=000011", strb); end
        checks++; if (mux_pc !== 2'b11) begin failures++; $display("[TB] FAIL jalr_mux_pc got=%b exp=11", mux_pc); end
        checks++; if (mux_tgt !== 2'b11) begin failures++; $display("[TB] FAIL jalr_mux_tgt got=%b exp=11", mux_tgt); end
        checks++; if (func_alu !== 2'b10) begin failures++; $display("[TB] FAIL jalr_func_alu got=%b exp=10", func_alu); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL jalr_instret got=%0d exp=%0d", instret, exp_ret); end
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL jalr_halted got=%b exp=1", halted); end
    endtask

    task automatic test_lw();
        opcode = OP_LW;
        to_exec();
        mem_ack = 1'b0;
        #1;
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL lw_exec_strb got=%b exp=000000", strb); end
        checks++; if (mux_alu2 !== 1'b1) begin failures++; $display("[TB] FAIL lw_mux_alu2 got=%b exp=1", mux_alu2); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++; if (strb !== 6'b110000) begin failures++; $display("[TB] FAIL lw_wait%0d_strb got=%b exp=110000", i, strb); end
        end
        next_cycle();
        mem_ack = 1'b1; halt = 1'b1;
        #1;
        checks++; if (strb !== 6'b110011) begin failures++; $display("[TB] FAIL lw_ack_strb got=%b exp=110011", strb); end
        checks++; if (mux_tgt !== 2'b10) begin failures++; $display("[TB] FAIL lw_mux_tgt got=%b exp=10", mux_tgt); end
        checks++; if (mux_pc !== 2'b01) begin failures++; $display("[TB] FAIL lw_mux_pc got=%b exp=01", mux_pc); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL lw_halted got=%b exp=1", halted); end
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL lw_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_sw();
        opcode = OP_SW;
        to_exec();
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL sw_exec_strb got=%b exp=000000", strb); end
        next_cycle();
        halt = 1'b1;
        #1;
        checks++; if (strb !== 6'b111010) begin failures++; $display("[TB] FAIL sw_mem_strb got=%b exp=111010", strb); end
        checks++; if (mux_alu2 !== 1'b1) begin failures++; $display("[TB] FAIL sw_mux_alu2 got=%b exp=1", mux_alu2); end
        checks++; if (mux_rf !== 1'b1) begin failures++; $display("[TB] FAIL sw_mux_rf got=%b exp=1", mux_rf); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL sw_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_timeout();
        opcode = OP_ADD; mem_ack = 1'b0; halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            checks++; if (strb !== 6'b100000) begin failures++; $display("[TB] FAIL to_wait%0d_strb got=%b exp=100000", i, strb); end
            checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL to_wait%0d_fault got=%b exp=0", i, fault); end
        end
        next_cycle();
        checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL to_fault got=%b exp=1", fault); end
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL to_fault_strb got=%b exp=000000", strb); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL to_fault_halted got=%b exp=0", halted); end
        mem_ack = 1'b1;
        repeat (3) next_cycle();
        checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL to_sticky got=%b exp=1", fault); end
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL to_sticky_strb got=%b exp=000000", strb); end
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL to_instret_pre got=%0d exp=%0d", instret, exp_ret); end
        rst = 1'b1; halt = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_ret = 2'd0;
        #1;
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL to_rst_fault got=%b exp=0", fault); end
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL to_rst_halted got=%b exp=1", halted); end
        checks++; if (instret !== 2'd0) begin failures++; $display("[TB] FAIL to_rst_instret got=%0d exp=0", instret); end
    endtask

    task automatic test_halt_mid_lw();
        opcode = OP_LW;
        to_exec();
        mem_ack = 1'b0;
        next_cycle();
        halt = 1'b1;
        #1;
        checks++; if (strb !== 6'b110000) begin failures++; $display("[TB] FAIL hlt_wait1_strb got=%b exp=110000", strb); end
        next_cycle();
        checks++; if (strb !== 6'b110000) begin failures++; $display("[TB] FAIL hlt_wait2_strb got=%b exp=110000", strb); end
        next_cycle();
        mem_ack = 1'b1;
        #1;
        checks++; if (strb !== 6'b110011) begin failures++; $display("[TB] FAIL hlt_ack_strb got=%b exp=110011", strb); end
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL hlt_halted got=%b exp=1", halted); end
        checks++; if (strb !== 6'b000000) begin failures++; $display("[TB] FAIL hlt_halted_strb got=%b exp=000000", strb); end
        next_cycle();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL hlt_stay got=%b exp=1", halted); end
        halt = 1'b0; opcode = OP_ADD;
        next_cycle();
        checks++; if (strb !== 6'b100100) begin failures++; $display("[TB] FAIL hlt_resume_strb got=%b exp=100100", strb); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL hlt_resume_halted got=%b exp=0", halted); end
        next_cycle();
        next_cycle();
        halt = 1'b1;
        exp_ret = exp_ret + 2'd1;
        next_cycle();
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL hlt_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_back_to_back();
        opcode = OP_NAND; halt = 1'b0; mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            checks++; if (strb !== 6'b100100) begin failures++; $display("[TB] FAIL b2b%0d_fetch got=%b exp=100100", k, strb); end
            next_cycle();
            next_cycle();
            if (k == 3) halt = 1'b1;
            #1;
            checks++; if (strb !== 6'b000011) begin failures++; $display("[TB] FAIL b2b%0d_exec got=%b exp=000011", k, strb); end
            checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL b2b%0d_instret got=%0d exp=%0d", k, instret, exp_ret); end
            exp_ret = exp_ret + 2'd1;
        end
        checks++; if (func_alu !== 2'b01) begin failures++; $display("[TB] FAIL b2b_func_alu got=%b exp=01", func_alu); end
        next_cycle();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL b2b_halted got=%b exp=1", halted); end
        checks++; if (instret !== exp_ret) begin failures++; $display("[TB] FAIL b2b_wrap got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_selects();
        opcode = OP_LUI; #1;
        checks++; if ({func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt} !== 7'b1010001) begin failures++; $display("[TB] FAIL sel_lui got=%b exp=1010001", {func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt}); end
        opcode = OP_ADDI; #1;
        checks++; if ({func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt} !== 7'b0001001) begin failures++; $display("[TB] FAIL sel_addi got=%b exp=0001001", {func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt}); end
        opcode = OP_NAND; #1;
        checks++; if ({func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt} !== 7'b0100001) begin failures++; $display("[TB] FAIL sel_nand got=%b exp=0100001", {func_alu, mux_alu1, mux_alu2, mux_rf, mux_tgt}); end
    endtask

    task automatic test_no_decode();
        halt2 = 1'b0; mem_ack = 1'b1; opcode = OP_ADD;
        next_cycle();
        checks++; if (nd_strb !== 6'b100100) begin failures++; $display("[TB] FAIL nd_fetch got=%b exp=100100", nd_strb); end
        next_cycle();
        halt2 = 1'b1;
        #1;
        checks++; if (nd_strb !== 6'b000011) begin failures++; $display("[TB] FAIL nd_exec got=%b exp=000011", nd_strb); end
        next_cycle();
        checks++; if (nd_halted !== 1'b1) begin failures++; $display("[TB] FAIL nd_halted got=%b exp=1", nd_halted); end
        checks++; if (nd_instret !== 16'd1) begin failures++; $display("[TB] FAIL nd_instret got=%0d exp=1", nd_instret); end
        checks++; if (nd_fault !== 1'b0) begin failures++; $display("[TB] FAIL nd_fault got=%b exp=0", nd_fault); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_beq_jalr();
        test_lw();
        test_sw();
        test_timeout();
        test_halt_mid_lw();
        test_back_to_back();
        test_selects();
        test_no_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
